// File: rtl/life_matrix_scanner.sv
// life_matrix_scanner: captures the Game of Life row stream into a double-buffered frame
// store and scans the visible frame onto an NxN LED matrix. Optional macro: SCAN_BLANK_EN.
module life_matrix_scanner #(
    parameter int N            = 8,
    parameter int HOLD         = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] row_in,
    input  logic         row_valid,
    input  logic         frame_start,
    output logic [N-1:0] row_sel,
    output logic [N-1:0] col_out,
    output logic         frame_swap,
    output logic         frame_drop
);

    localparam int RW    = (N > 1) ? $clog2(N) : 1;
    localparam int WW    = $clog2(N + 1);
    localparam int HSPAN = (HOLD > BLANK_CYCLES) ? HOLD : BLANK_CYCLES + 1;
    localparam int HW    = (HSPAN > 1) ? $clog2(HSPAN) : 1;
    localparam logic [N-1:0] ROW0 = N'(1);

    logic [N-1:0]  buf_a [N];
    logic [N-1:0]  buf_b [N];
    logic          front_is_b;
    logic [WW-1:0] wr_row;
    logic          swap_pending;
    logic [RW-1:0] scan_row;
    logic [HW-1:0] hold_cnt;

    logic          hold_end;
    logic          scan_wrap;
    logic          do_swap;
    logic          frame_mid;
    logic          start_ok;
    logic          start_drop;
    logic          cont_ok;
    logic          wr_last;
    logic          wr_en;
    logic [RW-1:0] wr_idx;
    logic [N-1:0]  front_row;

    // wr_row == N means idle: no frame is being captured into the back buffer.
    always_comb begin
        hold_end   = (hold_cnt == HW'(HOLD - 1));
        scan_wrap  = hold_end && (scan_row == RW'(N - 1));
        do_swap    = scan_wrap && swap_pending;
        frame_mid  = (wr_row != '0) && (wr_row < WW'(N));
        start_ok   = row_valid && frame_start && !swap_pending;
        start_drop = row_valid && frame_start && (swap_pending || frame_mid);
        cont_ok    = row_valid && !frame_start && (wr_row < WW'(N));
        wr_last    = cont_ok && (wr_row == WW'(N - 1));
        wr_en      = start_ok || cont_ok;
        wr_idx     = cont_ok ? wr_row[RW-1:0] : '0;
        front_row  = front_is_b ? buf_b[scan_row] : buf_a[scan_row];
    end

    // No write can coincide with a swap: swap_pending blocks new captures until it clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (wr_en) begin
            if (front_is_b) begin
                buf_a[wr_idx] <= row_in;
            end else begin
                buf_b[wr_idx] <= row_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_row       <= WW'(N);
            swap_pending <= 1'b0;
            front_is_b   <= 1'b0;
            scan_row     <= '0;
            hold_cnt     <= '0;
            row_sel      <= '0;
            col_out      <= '0;
            frame_swap   <= 1'b0;
            frame_drop   <= 1'b0;
        end else begin
            frame_drop <= start_drop;
            frame_swap <= do_swap;

            if (start_ok) begin
                wr_row <= WW'(1);
            end else if (row_valid && frame_start) begin
                wr_row <= WW'(N);
            end else if (cont_ok) begin
                wr_row <= wr_row + WW'(1);
            end

            // A frame completed on the wrap cycle itself waits for the following wrap.
            if (do_swap) begin
                front_is_b   <= !front_is_b;
                swap_pending <= 1'b0;
            end else if (wr_last) begin
                swap_pending <= 1'b1;
            end

            if (hold_end) begin
                hold_cnt <= '0;
                scan_row <= scan_wrap ? '0 : scan_row + RW'(1);
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end

`ifdef SCAN_BLANK_EN
            if (hold_cnt < HW'(BLANK_CYCLES)) begin
                row_sel <= '0;
                col_out <= '0;
            end else begin
                row_sel <= ROW0 << scan_row;
                col_out <= front_row;
            end
`else
            row_sel <= ROW0 << scan_row;
            col_out <= front_row;
`endif
        end
    end

endmodule

// File: tb/tb_life_matrix_scanner.sv
// Self-checking bench for life_matrix_scanner (N=8, HOLD=4, BLANK_CYCLES=1).
// Define SCAN_BLANK_EN for both bench and design to check the blanking build.
module tb_life_matrix_scanner;

    localparam int N     = 8;
    localparam int HOLD  = 4;
    localparam int BLANK = 1;
    localparam int SCAN  = N * HOLD;
`ifdef SCAN_BLANK_EN
    localparam int BLANK_EFF = BLANK;
`else
    localparam int BLANK_EFF = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] row_in = '0;
    logic         row_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [N-1:0] row_sel;
    logic [N-1:0] col_out;
    logic         frame_swap;
    logic         frame_drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [N-1:0] exp_q [$];
    logic [N-1:0] sel_q [$];

    life_matrix_scanner #(.N(N), .HOLD(HOLD), .BLANK_CYCLES(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .row_valid   (row_valid),
        .frame_start (frame_start),
        .row_sel     (row_sel),
        .col_out     (col_out),
        .frame_swap  (frame_swap),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the negedge after posedge c shows scan state from before c.
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit is_blank(input int c);
        return ((c - 1) % HOLD) < BLANK_EFF;
    endfunction

    function automatic logic [N-1:0] exp_sel(input int c);
        logic [N-1:0] one;
        one = 1;
        if (is_blank(c)) return '0;
        return one << (((c - 1) / HOLD) % N);
    endfunction

    task automatic send_row(input logic [N-1:0] d, input logic fs,
                            output logic drop, output logic swp);
        row_in      = d;
        row_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk);
        @(negedge clk);
        drop        = frame_drop;
        swp         = frame_swap;
        row_valid   = 1'b0;
        frame_start = 1'b0;
        row_in      = '0;
    endtask

    task automatic align(input int phase);
        int k;
        k = 0;
        while ((cyc % SCAN) != phase && k < 2 * SCAN) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (row_sel !== '0 || col_out !== '0 || frame_swap !== 1'b0 || frame_drop !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs sel=%h col=%h swap=%b drop=%b required all 0",
                     row_sel, col_out, frame_swap, frame_drop);
        end
        rst = 1'b1;
        for (int c = 1; c <= SCAN; c++) sel_q.push_back(exp_sel(c));
        for (int c = 1; c <= SCAN; c++) begin
            logic [N-1:0] es;
            @(negedge clk);
            es = sel_q.pop_front();
            checks++;
            if (row_sel !== es || col_out !== '0) begin
                failures++;
                $display("[TB] FAIL reset_scan cyc=%0d sel=%h col=%h required sel=%h col=00",
                         cyc, row_sel, col_out, es);
            end
        end
    endtask

    task automatic test_glider();
        logic drop, swp, got;
        logic [N-1:0] cur, ec;
        logic [N-1:0] glider [N] = '{8'h00, 8'h08, 8'h04, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
        cur = '0;
        align(0);
        for (int r = 0; r < N; r++) begin
            send_row(glider[r], r == 0, drop, swp);
            exp_q.push_back(glider[r]);
            checks++;
            if (drop !== 1'b0 || swp !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glider_write row=%0d drop=%b swap=%b required 0/0", r, drop, swp);
            end
        end
        got = 1'b0;
        for (int k = 0; k < 2 * SCAN && !got; k++) begin
            @(negedge clk);
            got = frame_swap;
        end
        checks++;
        if (got !== 1'b1 || (cyc % SCAN) != 0) begin
            failures++;
            $display("[TB] FAIL glider_swap seen=%b cyc=%0d required pulse at scan wrap", got, cyc);
        end
        for (int k = 0; k < SCAN; k++) begin
            @(negedge clk);
            if (((cyc - 1) % HOLD) == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            ec = is_blank(cyc) ? '0 : cur;
            checks++;
            if (row_sel !== exp_sel(cyc) || col_out !== ec || frame_swap !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glider_display cyc=%0d sel=%h col=%h swap=%b required sel=%h col=%h swap=0",
                         cyc, row_sel, col_out, frame_swap, exp_sel(cyc), ec);
            end
        end
    endtask

    task automatic test_drop_partial();
        logic drop, swp, got;
        logic [N-1:0] cur, ec;
        logic [N-1:0] dat [11] = '{8'hFF, 8'hFF, 8'hFF,
                                   8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        logic         fs  [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         edr [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cur = '0;
        align(0);
        for (int i = 0; i < 11; i++) begin
            send_row(dat[i], fs[i], drop, swp);
            if (i >= 3) exp_q.push_back(dat[i]);
            checks++;
            if (drop !== edr[i] || swp !== 1'b0) begin
                failures++;
                $display("[TB] FAIL partial_drop step=%0d drop=%b swap=%b required drop=%b swap=0",
                         i, drop, swp, edr[i]);
            end
        end
        got = 1'b0;
        for (int k = 0; k < 2 * SCAN && !got; k++) begin
            @(negedge clk);
            got = frame_swap;
        end
        checks++;
        if (got !== 1'b1 || (cyc % SCAN) != 0) begin
            failures++;
            $display("[TB] FAIL partial_swap seen=%b cyc=%0d required pulse at scan wrap", got, cyc);
        end
        for (int k = 0; k < SCAN; k++) begin
            @(negedge clk);
            if (((cyc - 1) % HOLD) == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            ec = is_blank(cyc) ? '0 : cur;
            checks++;
            if (row_sel !== exp_sel(cyc) || col_out !== ec) begin
                failures++;
                $display("[TB] FAIL partial_display cyc=%0d sel=%h col=%h required sel=%h col=%h",
                         cyc, row_sel, col_out, exp_sel(cyc), ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic drop, swp, got;
        logic [N-1:0] cur, ec, d;
        cur = '0;
        align(0);
        for (int i = 0; i < 2 * N; i++) begin
            d = (i < N) ? N'((i + 1) * 8'h11) : ((i == N) ? 8'hF0 : 8'h0F);
            send_row(d, (i % N) == 0, drop, swp);
            if (i < N) exp_q.push_back(d);
            checks++;
            if (drop !== (i == N) || swp !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_drop step=%0d drop=%b swap=%b required drop=%b swap=0",
                         i, drop, swp, i == N);
            end
        end
        got = 1'b0;
        for (int k = 0; k < 2 * SCAN && !got; k++) begin
            @(negedge clk);
            got = frame_swap;
        end
        checks++;
        if (got !== 1'b1 || (cyc % SCAN) != 0) begin
            failures++;
            $display("[TB] FAIL b2b_swap seen=%b cyc=%0d required pulse at scan wrap", got, cyc);
        end
        for (int k = 0; k < SCAN; k++) begin
            @(negedge clk);
            if (((cyc - 1) % HOLD) == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            ec = is_blank(cyc) ? '0 : cur;
            checks++;
            if (row_sel !== exp_sel(cyc) || col_out !== ec || frame_swap !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_display cyc=%0d sel=%h col=%h swap=%b required sel=%h col=%h swap=0",
                         cyc, row_sel, col_out, frame_swap, exp_sel(cyc), ec);
            end
        end
    endtask

    // Last row lands on the wrap edge: the old frame stays up for one more full scan.
    task automatic test_write_at_wrap();
        logic drop, swp, es;
        logic [N-1:0] cur, ec, d;
        cur = '0;
        for (int i = 0; i < N; i++) exp_q.push_back(N'((i + 1) * 8'h11));
        align(SCAN - N);
        for (int i = 0; i < N; i++) begin
            d = N'(1) << i;
            send_row(d, i == 0, drop, swp);
            exp_q.push_back(d);
            checks++;
            if (drop !== 1'b0 || swp !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_write row=%0d cyc=%0d drop=%b swap=%b required 0/0",
                         i, cyc, drop, swp);
            end
        end
        for (int k = 0; k < 2 * SCAN; k++) begin
            @(negedge clk);
            if (((cyc - 1) % HOLD) == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            ec = is_blank(cyc) ? '0 : cur;
            es = (k == SCAN - 1);
            checks++;
            if (row_sel !== exp_sel(cyc) || col_out !== ec || frame_swap !== es) begin
                failures++;
                $display("[TB] FAIL wrap_display cyc=%0d sel=%h col=%h swap=%b required sel=%h col=%h swap=%b",
                         cyc, row_sel, col_out, frame_swap, exp_sel(cyc), ec, es);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [N-1:0] ec, es;
        align(22);
        ec = is_blank(cyc) ? '0 : 8'h20;
        checks++;
        if (row_sel !== exp_sel(cyc) || col_out !== ec) begin
            failures++;
            $display("[TB] FAIL midscan_row5 cyc=%0d sel=%h col=%h required sel=%h col=%h",
                     cyc, row_sel, col_out, exp_sel(cyc), ec);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (row_sel !== '0 || col_out !== '0 || frame_swap !== 1'b0 || frame_drop !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset sel=%h col=%h swap=%b drop=%b required all 0",
                     row_sel, col_out, frame_swap, frame_drop);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= SCAN; c++) sel_q.push_back(exp_sel(c));
        for (int c = 1; c <= SCAN; c++) begin
            @(negedge clk);
            es = sel_q.pop_front();
            checks++;
            if (row_sel !== es || col_out !== '0 || frame_swap !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_scan cyc=%0d sel=%h col=%h swap=%b required sel=%h col=00 swap=0",
                         cyc, row_sel, col_out, frame_swap, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glider();
        test_drop_partial();
        test_back_to_back();
        test_write_at_wrap();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
